data_memory_mp: RTL and testbench
=================================

Name: data_memory_mp

Overview:
Parametrised multi-port data memory for the superscalar datapath, generalising the two-port word RAM used by the MEM stage. It provides NUM_PORTS independent read/write ports with byte enables, a selectable read latency, deterministic same-cycle write-collision and read-during-write rules, and out-of-range error flags. After reset it runs a zero-fill sweep and signals Ready before accepting accesses.

Parameters:
DATA_W, 32, data word width in bits (multiple of 8)
ADDR_W, 10, word-address width per port
DEPTH, 1000, number of words (DEPTH <= 2**ADDR_W)
NUM_PORTS, 2, number of access ports (1..4)
READ_LAT, 1, read latency in cycles (1 or 2)
RAW_MODE, 0, read-during-write: 0 = old data (read-first), 1 = new data (write-first)

Ports:
Clk  input  1  clock, all state on rising edge
Rst_n  input  1  asynchronous, active-low reset
RE  input  NUM_PORTS  read enable, bit i = port i
WE  input  NUM_PORTS  write enable, bit i = port i
BE  input  NUM_PORTS*DATA_W/8  byte enables, port i at [i*DATA_W/8 +: DATA_W/8]
A  input  NUM_PORTS*ADDR_W  word address, port i at [i*ADDR_W +: ADDR_W]
WD  input  NUM_PORTS*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
RD  output  NUM_PORTS*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
RVALID  output  NUM_PORTS  one-cycle pulse: RD slice i valid
ERR  output  NUM_PORTS  one-cycle pulse: port i access was out of range
Ready  output  1  high once initialisation sweep is complete

Behaviour:
- FSM states: INIT, RUN. Rst_n low (async): state=INIT, init counter=0, Ready=0, RD=0, RVALID=0, ERR=0, latency pipeline cleared. Array contents not reset asynchronously.
- INIT: one word per cycle, RAM[counter]<=0, counter increments; after word DEPTH-1 is written, state=RUN, Ready=1 from the next cycle. INIT lasts exactly DEPTH cycles after Rst_n rises. Requests during INIT are ignored: no writes, RVALID=0, ERR=0.
- Rst_n asserted mid-INIT or mid-RUN: immediate return to INIT with counter=0; in-flight reads dropped (RVALID=0).
- Read (RUN, RE[i]=1, A_i<DEPTH): RD_i and RVALID[i]=1 appear READ_LAT cycles after the request edge. Fully pipelined: one read per port per cycle. RD_i holds its last value while RVALID[i]=0.
- Write (RUN, WE[i]=1, A_i<DEPTH): at the request edge, each byte lane b with BE_i[b]=1 takes WD_i lane b; other lanes unchanged. WE with BE all zero: no change, no error.
- Out of range (A_i>=DEPTH with RE[i] or WE[i]): no array access; ERR[i]=1 READ_LAT cycles later; if RE[i] was set, RVALID[i]=1 with RD_i=0 in the same cycle.
- Write collision: several ports write the same word in one cycle -> merged per byte lane; highest-indexed port with its BE bit set wins that lane.
- Read during write, same word (same or different port): RAW_MODE=0 returns the pre-edge word; RAW_MODE=1 returns the fully merged post-edge word.
- Ports are otherwise independent; no back-pressure, no stall output.

Test Plan:
- Reset/init: DEPTH=8, release Rst_n -> Ready=0 for 8 cycles, then 1; read all 8 words -> RD=0x00000000, RVALID pulses; requests issued during INIT produce no RVALID and no writes.
- Byte enables: port0 writes 0xAABBCCDD BE=1111 to addr 5, then 0x11223344 BE=0101 -> read addr 5 returns 0xAA22CC44 after READ_LAT cycles.
- Collision: same cycle port0 writes 0x11111111 BE=1111 and port1 writes 0x22222222 BE=0011 to addr 3 -> later read returns 0x11112222.
- Read-during-write: addr 7 holds 0x5; port1 writes 0x9 while port0 reads addr 7 -> RD0=0x5 with RAW_MODE=0, 0x9 with RAW_MODE=1; next read returns 0x9 in both modes.
- Range/latency: READ_LAT=2, DEPTH=1000, port0 reads addr 1000 -> two cycles later RVALID0=1, ERR0=1, RD0=0; memory unchanged; back-to-back reads of addrs 1,2,3 return data on 3 consecutive cycles.
- Reset mid-operation: assert Rst_n low with reads in flight -> RVALID/ERR/RD drop to 0 immediately, Ready=0, full DEPTH-cycle sweep reruns, prior contents read back as 0.

Source files
------------

// File: rtl/data_memory_mp.sv
// Multi-port byte-enabled data memory with zero-fill sweep after reset,
// configurable read latency, and deterministic collision / read-during-write rules.
module data_memory_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 1000,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned RAW_MODE  = 0
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [NUM_PORTS-1:0]            RE,
    input  logic [NUM_PORTS-1:0]            WE,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   BE,
    input  logic [NUM_PORTS*ADDR_W-1:0]     A,
    input  logic [NUM_PORTS*DATA_W-1:0]     WD,
    output logic [NUM_PORTS*DATA_W-1:0]     RD,
    output logic [NUM_PORTS-1:0]            RVALID,
    output logic [NUM_PORTS-1:0]            ERR,
    output logic                            Ready
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   cnt_q, cnt_d;
    logic              run;
    logic              init_we;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] addr   [NUM_PORTS];
    logic [IdxW-1:0]   idx    [NUM_PORTS];
    logic [NUM_PORTS-1:0] in_rng, rd_req, wr_ok, err_s;
    logic [NUM_PORTS*DATA_W-1:0] rd_s;
    logic [DATA_W-1:0] word;

    logic [NUM_PORTS-1:0]        p_v, p_e;
    logic [NUM_PORTS*DATA_W-1:0] p_d;
    logic [NUM_PORTS-1:0]        rvalid_q, err_q;
    logic [NUM_PORTS*DATA_W-1:0] rd_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IdxW'(DEPTH - 1)) begin
                state_d = StRun;
                cnt_d   = '0;
            end
        end
    end

    always_comb begin
        run     = (state_q == StRun);
        init_we = (state_q == StInit);
        Ready   = run;
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            addr[i]   = A[i*ADDR_W +: ADDR_W];
            idx[i]    = addr[i][IdxW-1:0];
            in_rng[i] = 32'(addr[i]) < DEPTH;
            rd_req[i] = run & RE[i];
            wr_ok[i]  = run & WE[i] & in_rng[i];
            err_s[i]  = run & (RE[i] | WE[i]) & ~in_rng[i];
        end
    end

    // Write-first mode overlays this cycle's writes in port order so the highest port wins.
    always_comb begin
        rd_s = '0;
        word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            word = in_rng[i] ? mem_q[idx[i]] : '0;
            if (RAW_MODE != 0 && in_rng[i]) begin
                for (int j = 0; j < NUM_PORTS; j++) begin
                    if (wr_ok[j] && idx[j] == idx[i]) begin
                        for (int b = 0; b < BeW; b++) begin
                            if (BE[j*BeW + b]) word[b*8 +: 8] = WD[j*DATA_W + b*8 +: 8];
                        end
                    end
                end
            end
            rd_s[i*DATA_W +: DATA_W] = word;
        end
    end

    // Later non-blocking assignments take precedence, giving the per-lane collision merge.
    always_ff @(posedge Clk) begin
        if (init_we) mem_q[cnt_q] <= '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int b = 0; b < BeW; b++) begin
                if (wr_ok[j] && BE[j*BeW + b]) begin
                    mem_q[idx[j]][b*8 +: 8] <= WD[j*DATA_W + b*8 +: 8];
                end
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [NUM_PORTS-1:0]        sv_q, se_q;
            logic [NUM_PORTS*DATA_W-1:0] sd_q;
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    sv_q <= '0;
                    se_q <= '0;
                    sd_q <= '0;
                end else begin
                    sv_q <= rd_req;
                    se_q <= err_s;
                    sd_q <= rd_s;
                end
            end
            assign p_v = sv_q;
            assign p_e = se_q;
            assign p_d = sd_q;
        end else begin : g_lat1
            assign p_v = rd_req;
            assign p_e = err_s;
            assign p_d = rd_s;
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rd_q     <= '0;
        end else begin
            rvalid_q <= p_v;
            err_q    <= p_e;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (p_v[i]) rd_q[i*DATA_W +: DATA_W] <= p_d[i*DATA_W +: DATA_W];
            end
        end
    end

    assign RD     = rd_q;
    assign RVALID = rvalid_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_data_memory_mp.sv
// Bench for data_memory_mp: two instances (latency 1 read-first, latency 2 write-first)
// share stimulus and are checked against a word-array reference model.
module tb_data_memory_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned D  = 12;
    localparam int unsigned P  = 2;
    localparam int unsigned BW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic [P-1:0]    re, we;
    logic [P*BW-1:0] be;
    logic [P*AW-1:0] a;
    logic [P*DW-1:0] wd;
    logic [P*DW-1:0] rd_a, rd_b;
    logic [P-1:0]    rv_a, rv_b, er_a, er_b;
    logic            rdy_a, rdy_b;

    always #5 clk = ~clk;

    data_memory_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NUM_PORTS(P),
                     .READ_LAT(1), .RAW_MODE(0)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .RE(re), .WE(we), .BE(be), .A(a), .WD(wd),
        .RD(rd_a), .RVALID(rv_a), .ERR(er_a), .Ready(rdy_a));

    data_memory_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .NUM_PORTS(P),
                     .READ_LAT(2), .RAW_MODE(1)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .RE(re), .WE(we), .BE(be), .A(a), .WD(wd),
        .RD(rd_b), .RVALID(rv_b), .ERR(er_b), .Ready(rdy_b));

    int checks   = 0;
    int failures = 0;

    // Reference model: memory image, remaining sweep cycles, per-edge result history.
    logic [DW-1:0]   mmem [D];
    int              init_left;
    int              n = 0;
    logic [P-1:0]    hv [4];
    logic [P-1:0]    he [4];
    logic [P*DW-1:0] h_old [4];
    logic [P*DW-1:0] h_new [4];
    logic [P*DW-1:0] xrd_a, xrd_b;

    typedef struct {
        logic [P-1:0]    re;
        logic [P-1:0]    we;
        logic [P*BW-1:0] be;
        logic [P*AW-1:0] a;
        logic [P*DW-1:0] wd;
        bit              chk;
        logic [DW-1:0]   exp_old;
        logic [DW-1:0]   exp_new;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 4; k++) begin
            hv[k] = '0; he[k] = '0; h_old[k] = '0; h_new[k] = '0;
        end
        xrd_a = '0;
        xrd_b = '0;
    endtask

    task automatic idle();
        re = '0; we = '0; be = '0; a = '0; wd = '0;
    endtask

    task automatic rand_req();
        re = P'($urandom);
        we = P'($urandom);
        be = (P*BW)'($urandom);
        wd = {$urandom, $urandom};
        for (int i = 0; i < P; i++) a[i*AW +: AW] = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) a[AW +: AW] = a[0 +: AW];
    endtask

    // Model the edge for the current inputs, clock once, compare both instances.
    task automatic step();
        int s, sp, ai;
        logic [DW-1:0] tmp [D];
        s  = n % 4;
        sp = (n + 3) % 4;
        hv[s] = '0; he[s] = '0; h_old[s] = '0; h_new[s] = '0;
        if (init_left == 0) begin
            tmp = mmem;
            for (int j = 0; j < P; j++) begin
                ai = int'(a[j*AW +: AW]);
                if (we[j] && ai < D)
                    for (int b = 0; b < BW; b++)
                        if (be[j*BW + b]) tmp[ai][b*8 +: 8] = wd[j*DW + b*8 +: 8];
            end
            for (int i = 0; i < P; i++) begin
                ai = int'(a[i*AW +: AW]);
                hv[s][i] = re[i];
                he[s][i] = (re[i] | we[i]) && ai >= D;
                if (ai < D) begin
                    h_old[s][i*DW +: DW] = mmem[ai];
                    h_new[s][i*DW +: DW] = tmp[ai];
                end
            end
            mmem = tmp;
        end else begin
            mmem[D - init_left] = '0;
            init_left--;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < P; i++) begin
            if (hv[s][i])  xrd_a[i*DW +: DW] = h_old[s][i*DW +: DW];
            if (hv[sp][i]) xrd_b[i*DW +: DW] = h_new[sp][i*DW +: DW];
        end
        check("lat1_read_first", {11'd0, rv_a, er_a, rd_a, rdy_a},
              {11'd0, hv[s], he[s], xrd_a, 1'(init_left == 0)});
        check("lat2_write_first", {11'd0, rv_b, er_b, rd_b, rdy_b},
              {11'd0, hv[sp], he[sp], xrd_b, 1'(init_left == 0)});
        n++;
    endtask

    task automatic read_all();
        for (int w = 0; w < D; w++) begin
            idle();
            re = 2'b11;
            a  = {AW'(D - 1 - w), AW'(w)};
            step();
        end
        idle();
        step();
        step();
    endtask

    initial begin
        tbl[0]  = '{2'b00, 2'b01, 8'h0F, 8'h05, 64'h00000000_AABBCCDD, 1'b0, 32'h0, 32'h0};
        tbl[1]  = '{2'b00, 2'b01, 8'h05, 8'h05, 64'h00000000_11223344, 1'b0, 32'h0, 32'h0};
        tbl[2]  = '{2'b01, 2'b00, 8'h00, 8'h05, 64'h0, 1'b1, 32'hAA22CC44, 32'hAA22CC44};
        tbl[3]  = '{2'b00, 2'b11, 8'h3F, 8'h33, 64'h22222222_11111111, 1'b0, 32'h0, 32'h0};
        tbl[4]  = '{2'b01, 2'b00, 8'h00, 8'h03, 64'h0, 1'b1, 32'h11112222, 32'h11112222};
        tbl[5]  = '{2'b00, 2'b01, 8'h0F, 8'h07, 64'h00000000_00000005, 1'b0, 32'h0, 32'h0};
        tbl[6]  = '{2'b01, 2'b10, 8'hF0, 8'h77, 64'h00000009_00000000, 1'b1, 32'h5, 32'h9};
        tbl[7]  = '{2'b01, 2'b00, 8'h00, 8'h07, 64'h0, 1'b1, 32'h9, 32'h9};
        tbl[8]  = '{2'b01, 2'b00, 8'h00, 8'h0C, 64'h0, 1'b1, 32'h0, 32'h0};
        tbl[9]  = '{2'b00, 2'b10, 8'h00, 8'h00, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 32'h0, 32'h0};
        tbl[10] = '{2'b01, 2'b00, 8'h00, 8'h00, 64'h0, 1'b1, 32'h0, 32'h0};
        tbl[11] = '{2'b00, 2'b01, 8'h0F, 8'h0F, 64'h00000000_DEADBEEF, 1'b0, 32'h0, 32'h0};

        idle();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #10;
        check("reset_state_a", {11'd0, rv_a, er_a, rd_a, rdy_a}, 80'd0);
        check("reset_state_b", {11'd0, rv_b, er_b, rd_b, rdy_b}, 80'd0);
        clear_hist();
        init_left = D;
        @(negedge clk);
        rst_n = 1'b1;

        // Requests during the sweep must be ignored.
        for (int c = 0; c < D; c++) begin
            rand_req();
            step();
        end
        read_all();

        for (int t = 0; t < 12; t++) begin
            re = tbl[t].re; we = tbl[t].we; be = tbl[t].be; a = tbl[t].a; wd = tbl[t].wd;
            step();
            if (tbl[t].chk) check("tbl_read_first", 80'(rd_a[DW-1:0]), 80'(tbl[t].exp_old));
            idle();
            step();
            if (tbl[t].chk) check("tbl_write_first", 80'(rd_b[DW-1:0]), 80'(tbl[t].exp_new));
        end

        // Back-to-back reads of words 1, 2, 3.
        for (int w = 1; w <= 3; w++) begin
            idle();
            re = 2'b01;
            a  = AW'(w);
            step();
        end
        idle();
        step();
        step();

        for (int c = 0; c < 400; c++) begin
            rand_req();
            step();
        end

        // Reset with reads in flight.
        idle();
        re = 2'b11;
        a  = {AW'(2), AW'(5)};
        step();
        re = 2'b11;
        a  = {AW'(13), AW'(4)};
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", {11'd0, rv_a, er_a, rd_a, rdy_a}, 80'd0);
        check("async_reset_b", {11'd0, rv_b, er_b, rd_b, rdy_b}, 80'd0);
        clear_hist();
        init_left = D;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("held_reset_a", {11'd0, rv_a, er_a, rd_a, rdy_a}, 80'd0);
        check("held_reset_b", {11'd0, rv_b, er_b, rd_b, rdy_b}, 80'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < D; c++) begin
            rand_req();
            step();
        end
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
